pc_fetch_stage: RTL and testbench
=================================

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter: N, default 32, datapath/address width.
REQ-002 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 Clocking: one clock; reset is synchronous and active-low.
REQ-004 Port `clk`, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port `rst_n`, input, 1, reset, synchronous, active-low.
REQ-006 Port `pc_next`, input, N, next PC from the PC-select mux.
REQ-007 Port `stall`, input, 1, hazard unit holds IF/ID.
REQ-008 Port `flush`, input, 1, redirect: branch/JAL/JALR taken, `pc_next` holds the target.
REQ-009 Port `pc`, output, N, current fetch PC.
REQ-010 Port `pc_plus4`, output, N, `pc` + 4; feeds mux in0.
REQ-011 Port `imem_req`, output, 1, instruction-memory request valid.
REQ-012 Port `imem_addr`, output, N, request address.
REQ-013 Port `imem_gnt`, input, 1, request accepted this cycle.
REQ-014 Port `imem_rvalid`, input, 1, read data valid.
REQ-015 Port `imem_rdata`, input, 32, instruction word.
REQ-016 Port `if_id_valid`, output, 1, IF/ID register holds a live instruction.
REQ-017 Port `if_id_instr`, output, 32, IF/ID instruction.
REQ-018 Port `if_id_pc`, output, N, IF/ID PC.
REQ-019 Port `if_id_pc_plus4`, output, N, IF/ID PC + 4.

Function
REQ-020 FSM states: S_REQ, S_WAIT, S_HOLD; at most one outstanding memory request.
REQ-021 S_REQ: `imem_req`=1 and `imem_addr`=`pc`; `imem_gnt`=1 moves to S_WAIT, else stay.
REQ-022 S_WAIT, `imem_rvalid`=1, no stall, no drop pending:
  - IF/ID loads {rdata, pc, pc+4} with valid=1.
  - `pc` <= `pc_next`; go to S_REQ.
REQ-023 S_WAIT, `imem_rvalid`=1, `stall`=1:
  - rdata captured in a one-entry hold buffer; `pc` unchanged; go to S_HOLD.
REQ-024 S_HOLD, `stall`=0: IF/ID loads the hold buffer, `pc` <= `pc_next`, go to S_REQ.
REQ-025 IF/ID outputs are held unchanged while `stall`=1.
REQ-026 `flush`=1 in any state:
  - `pc` <= `pc_next`; `if_id_valid` <= 0; `if_id_instr` <= NOP 32'h0000_0013.
  - Hold buffer discarded; flush has priority over stall.
REQ-027 Flush in S_WAIT (or in S_REQ with `imem_gnt`=1):
  - Set a drop flag; the next `imem_rvalid` is discarded.
  - Then go to S_REQ at the redirected `pc`.
REQ-028 Flush in S_REQ without gnt or in S_HOLD: go to S_REQ; no drop.
REQ-029 Flush coincident with `imem_rvalid`: the returning word is discarded, no drop flag set.
REQ-030 Every load of `pc` clears bits [1:0] (word-aligned fetch).
REQ-031 `pc_plus4` = `pc` + 4, modulo 2^N, combinational; 32'hFFFF_FFFC wraps to 0.
REQ-032 `imem_req`=0 outside S_REQ.

Reset
REQ-033 On `rst_n`=0 at a clock edge:
  - `pc`=RESET_PC, state=S_REQ, drop flag=0, hold buffer cleared.
  - `if_id_valid`=0, `if_id_instr`=32'h0000_0013, `if_id_pc`=0, `if_id_pc_plus4`=0.
REQ-034 Reset mid-request abandons the outstanding request; an `imem_rvalid` arriving in the first post-reset cycle is ignored.
REQ-035 First request issues in the first cycle after `rst_n` returns high.

Structure
REQ-036 A shared package holds: the FSM state enum, the NOP constant 32'h0000_0013, and the default RESET_PC.
REQ-037 One sub-module is natural: `pc_reg` (N-bit register with sync active-low reset, enable, alignment clear).

Verification
REQ-038 Reset release, `pc_next`=`pc_plus4`, gnt=1, rvalid one cycle later:
  - imem_addr sequence 0,4,8.
  - IF/ID gets instr at pc 0 then 4, pc_plus4 4 then 8.
REQ-039 Stall asserted 3 cycles while rvalid returns word 32'h00A00093 at pc 8:
  - IF/ID unchanged during the stall.
  - After release, IF/ID = {32'h00A00093, 8, 12}.
REQ-040 Flush with `pc_next`=32'h0000_0100 while S_WAIT for pc 12:
  - Word for pc 12 dropped; if_id_valid=0, if_id_instr=NOP.
  - Next imem_addr = 32'h100.
REQ-041 Flush and stall in the same cycle, `pc_next`=32'h40: flush wins; pc=32'h40, if_id_valid=0.
REQ-042 `pc_next`=32'h0000_0106: pc loads 32'h104. PC 32'hFFFF_FFFC: pc_plus4=0.
REQ-043 `rst_n`=0 during S_WAIT: pc=RESET_PC, the late rvalid is ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding, the canonical NOP and the boot PC.
package pc_fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_stage_pc_reg.sv
// Program counter register.
// Every load, including reset, forces word alignment.
module pc_reg #(
  parameter int           N         = 32,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] pc_q;
  logic [N-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (en) begin
      pc_d = {d[N-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= {RESET_VAL[N-1:2], 2'b00};
    end else begin
      pc_q <= pc_d;
    end
  end

  assign q = pc_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// IF stage: PC register, single-outstanding imem fetch FSM and IF/ID register.
// A word returning after a redirect is dropped via the drop flag.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter int           N        = 32,
  parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] pc_next,
  input  logic         stall,
  input  logic         flush,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic         if_id_valid,
  output logic [31:0]  if_id_instr,
  output logic [N-1:0] if_id_pc,
  output logic [N-1:0] if_id_pc_plus4
);

  fetch_state_e state_q, state_d;
  logic         drop_q, drop_d;
  logic [31:0]  hold_q, hold_d;
  logic         ifv_q, ifv_d;
  logic [31:0]  ifi_q, ifi_d;
  logic [N-1:0] ifpc_q, ifpc_d;
  logic [N-1:0] ifp4_q, ifp4_d;
  logic         pc_en;
  logic         deliver;
  logic [31:0]  dlv_instr;

  pc_reg #(
    .N        (N),
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pc_en),
    .d    (pc_next),
    .q    (pc)
  );

  assign pc_plus4  = pc + N'(4);
  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc;

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    hold_d    = hold_q;
    ifv_d     = ifv_q;
    ifi_d     = ifi_q;
    ifpc_d    = ifpc_q;
    ifp4_d    = ifp4_q;
    pc_en     = 1'b0;
    deliver   = 1'b0;
    dlv_instr = hold_q;

    unique case (state_q)
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (stall) begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end else begin
            deliver   = 1'b1;
            dlv_instr = imem_rdata;
            state_d   = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          deliver   = 1'b1;
          dlv_instr = hold_q;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    // ID consumes IF/ID each unstalled cycle; no new word means a bubble
    if (deliver) begin
      ifv_d  = 1'b1;
      ifi_d  = dlv_instr;
      ifpc_d = pc;
      ifp4_d = pc_plus4;
      pc_en  = 1'b1;
    end else if (!stall) begin
      ifv_d = 1'b0;
    end

    if (flush) begin
      pc_en   = 1'b1;
      ifv_d   = 1'b0;
      ifi_d   = NOP_INSTR;
      hold_d  = '0;
      drop_d  = 1'b0;
      state_d = S_REQ;
      // a request is still in flight: wait out its data before refetching
      if ((state_q == S_WAIT && !imem_rvalid) ||
          (state_q == S_REQ && imem_gnt)) begin
        drop_d  = 1'b1;
        state_d = S_WAIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      drop_q  <= 1'b0;
      hold_q  <= '0;
      ifv_q   <= 1'b0;
      ifi_q   <= NOP_INSTR;
      ifpc_q  <= '0;
      ifp4_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
      ifv_q   <= ifv_d;
      ifi_q   <= ifi_d;
      ifpc_q  <= ifpc_d;
      ifp4_q  <= ifp4_d;
    end
  end

  assign if_id_valid    = ifv_q;
  assign if_id_instr    = ifi_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_pc_plus4 = ifp4_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage with a queue of expected IF/ID loads.
// The bench plays the instruction memory and the PC-select mux.
module tb_pc_fetch_stage;

  localparam int N = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] pc_next;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic [N-1:0] pc;
  logic [N-1:0] pc_plus4;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_gnt = 1'b0;
  logic         imem_rvalid = 1'b0;
  logic [31:0]  imem_rdata = '0;
  logic         if_id_valid;
  logic [31:0]  if_id_instr;
  logic [N-1:0] if_id_pc;
  logic [N-1:0] if_id_pc_plus4;

  logic         redirect = 1'b0;
  logic [31:0]  target = '0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pp4;
  } ifid_t;

  ifid_t sb[$];
  int vectors = 0;
  int misses  = 0;

  assign pc_next = redirect ? target : pc_plus4;

  always #5 clk = ~clk;

  pc_fetch_stage #(
    .N       (N),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_next       (pc_next),
    .stall         (stall),
    .flush         (flush),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    ifid_t e;
    if (sb.size() == 0) begin
      vectors++;
      misses++;
      $error("FAIL %s: observed load expected none queued", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_v"},   if_id_valid,    1);
      chk({tag, "_i"},   if_id_instr,    e.instr);
      chk({tag, "_pc"},  if_id_pc,       e.pc);
      chk({tag, "_pp4"}, if_id_pc_plus4, e.pp4);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] instr,
                       input logic [31:0] addr);
    chk({tag, "_req"}, imem_req, 1);
    chk({tag, "_addr"}, imem_addr, addr);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    chk({tag, "_noreq"}, imem_req, 0);
    sb.push_back(ifid_t'{instr, addr, addr + 32'd4});
    imem_rvalid = 1'b1;
    imem_rdata  = instr;
    tick();
    imem_rvalid = 1'b0;
    check_out(tag);
  endtask

  task automatic do_flush(input logic [31:0] t, input logic st);
    flush    = 1'b1;
    redirect = 1'b1;
    target   = t;
    stall    = st;
    tick();
    flush    = 1'b0;
    redirect = 1'b0;
    stall    = 1'b0;
  endtask

  initial begin
    int n;

    tick();
    tick();
    chk("rst_pc",    pc,             0);
    chk("rst_v",     if_id_valid,    0);
    chk("rst_i",     if_id_instr,    NOP);
    chk("rst_ifpc",  if_id_pc,       0);
    chk("rst_ifpp4", if_id_pc_plus4, 0);
    rst_n = 1'b1;

    fetch("seq0", 32'h0010_0093, 32'h0);
    fetch("seq1", 32'h0020_0113, 32'h4);
    chk("seq_pc", pc, 32'h8);

    chk("st_addr", imem_addr, 32'h8);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    sb.push_back(ifid_t'{32'h00A0_0093, 32'h8, 32'hC});
    stall       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00A0_0093;
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_rvalid = 1'b0;
      chk("st_hold_i",  if_id_instr, 32'h0020_0113);
      chk("st_hold_pc", if_id_pc,    32'h4);
      chk("st_pc",      pc,          32'h8);
      chk("st_noreq",   imem_req,    0);
    end
    stall = 1'b0;
    tick();
    check_out("st_rel");
    chk("st_pc_after", pc, 32'hC);

    chk("fl_addr", imem_addr, 32'hC);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    do_flush(32'h0000_0100, 1'b0);
    chk("fl_v",  if_id_valid, 0);
    chk("fl_i",  if_id_instr, NOP);
    chk("fl_pc", pc,          32'h100);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk("fl_drop_v", if_id_valid, 0);
    chk("fl_drop_i", if_id_instr, NOP);
    n = 0;
    while (!imem_req && n < 4) begin
      tick();
      n++;
    end
    chk("fl_req",  imem_req,  1);
    chk("fl_addr", imem_addr, 32'h100);

    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    stall       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    tick();
    imem_rvalid = 1'b0;
    do_flush(32'h0000_0040, 1'b1);
    chk("fs_pc",  pc,          32'h40);
    chk("fs_v",   if_id_valid, 0);
    chk("fs_i",   if_id_instr, NOP);
    chk("fs_req", imem_req,    1);
    fetch("fs_next", 32'h0030_0193, 32'h40);

    do_flush(32'h0000_0106, 1'b0);
    chk("al_pc",   pc,        32'h104);
    chk("al_addr", imem_addr, 32'h104);
    do_flush(32'hFFFF_FFFC, 1'b0);
    chk("wr_pc",  pc,       32'hFFFF_FFFC);
    chk("wr_pp4", pc_plus4, 32'h0);
    fetch("wr_f", 32'h0040_0213, 32'hFFFF_FFFC);
    chk("wr_pc2", pc, 32'h0);

    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst_n    = 1'b0;
    tick();
    chk("mr_pc", pc,          0);
    chk("mr_v",  if_id_valid, 0);
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_0BAD;
    tick();
    imem_rvalid = 1'b0;
    chk("mr_late_v", if_id_valid, 0);
    chk("mr_late_i", if_id_instr, NOP);
    fetch("mr_f", 32'h0050_0293, 32'h0);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
